bsg_idiv_iterative_tagged: RTL

Self-contained iterative integer divider with a generalised radix.
- Datapath and controller in one block; computes quotient and remainder, signed or unsigned, bits_per_iter_p quotient bits per cycle.
- Each request carries a tag that comes back with its result, so a multi-issue core can match out-of-order results.
- Sits behind the integer issue queue: valid/ready input, valid/yumi output.

---
 rtl/bsg_idiv_pkg.sv | 23 ++
 rtl/bsg_counter_up_down.sv | 34 +++
 rtl/bsg_idiv_radix_step.sv | 31 +++
 rtl/bsg_idiv_iterative_tagged.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_idiv_pkg.sv
// Shared types and elaboration helpers for the tagged iterative divider.
// Feature macro used by the divider top: BSG_IDIV_EARLY_TERM_EN.
package bsg_idiv_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StCalc,
    StFix,
    StDone
  } idiv_state_e;

  // Only radix 2, 4 and 16 are supported by the chained step.
  function automatic bit legal_bits_per_iter(int unsigned bits);
    return (bits == 1) || (bits == 2) || (bits == 4);
  endfunction

  // Bits needed to hold the values 0..x inclusive.
  function automatic int unsigned bsg_width(int unsigned x);
    return $clog2(x + 1);
  endfunction

endpackage

// File: rtl/bsg_counter_up_down.sv
// Up/down counter primitive: count += up - down each cycle.
module bsg_counter_up_down
  import bsg_idiv_pkg::*;
#(
  parameter int unsigned max_val_p = 32
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [bsg_width(max_val_p)-1:0] up,
  input  logic                           down,
  output logic [bsg_width(max_val_p)-1:0] count
);

  localparam int unsigned CntW = bsg_width(max_val_p);

  logic [CntW-1:0] count_q, count_d;

  // Next count from the step inputs.
  always_comb begin
    count_d = count_q + up - CntW'(down);
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/bsg_idiv_radix_step.sv
// Combinational restoring-division step resolving bits_per_iter_p quotient
// bits per call. The stored remainder is always below the divisor, so it fits
// in width_p bits; the shifted working value needs width_p+1.
module bsg_idiv_radix_step #(
  parameter int unsigned width_p         = 32,
  parameter int unsigned bits_per_iter_p = 1
) (
  input  logic [width_p-1:0]         partial_rem,
  input  logic [bits_per_iter_p-1:0] dvd_bits,
  input  logic [width_p-1:0]         divisor,
  output logic [bits_per_iter_p-1:0] quot_bits,
  output logic [width_p-1:0]         next_rem
);

  logic [width_p:0] work;

  // Chain of shift / compare / subtract steps, MSB of dvd_bits first.
  always_comb begin
    quot_bits = '0;
    work      = {1'b0, partial_rem};
    for (int i = int'(bits_per_iter_p) - 1; i >= 0; i--) begin
      work = {work[width_p-1:0], dvd_bits[i]};
      if (work >= {1'b0, divisor}) begin
        work         = work - {1'b0, divisor};
        quot_bits[i] = 1'b1;
      end
    end
    next_rem = work[width_p-1:0];
  end

endmodule

// File: rtl/bsg_idiv_iterative_tagged.sv
// Tagged iterative integer divider (signed/unsigned), valid/ready in,
// valid/yumi out. Define BSG_IDIV_EARLY_TERM_EN to skip leading zero
// quotient bits of the dividend; results are identical either way.
module bsg_idiv_iterative_tagged
  import bsg_idiv_pkg::*;
#(
  parameter int unsigned width_p         = 32,
  parameter int unsigned bits_per_iter_p = 1,
  parameter int unsigned tag_width_p     = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   v_i,
  output logic                   ready_and_o,
  input  logic [width_p-1:0]     dividend_i,
  input  logic [width_p-1:0]     divisor_i,
  input  logic                   signed_i,
  input  logic [tag_width_p-1:0] tag_i,
  output logic                   v_o,
  output logic [width_p-1:0]     quotient_o,
  output logic [width_p-1:0]     remainder_o,
  output logic                   div_by_zero_o,
  output logic [tag_width_p-1:0] tag_o,
  input  logic                   yumi_i
);

  localparam int unsigned Iters  = width_p / bits_per_iter_p;
  localparam int unsigned CntW   = bsg_width(Iters);
  localparam int unsigned LzW    = $clog2(width_p + 1);
  localparam int unsigned BShift = $clog2(bits_per_iter_p);

  if (!legal_bits_per_iter(bits_per_iter_p) || (width_p % bits_per_iter_p) != 0) begin : g_bad_cfg
    $error("bsg_idiv_iterative_tagged: illegal bits_per_iter_p / width_p combination");
  end

  idiv_state_e state_q, state_d;

  logic [width_p-1:0]     dividend_q, dividend_d;
  logic [width_p-1:0]     divisor_q, divisor_d;
  logic                   signed_q, signed_d;
  logic [tag_width_p-1:0] tag_q, tag_d;
  logic                   q_neg_q, q_neg_d;
  logic                   r_neg_q, r_neg_d;
  logic [width_p-1:0]     dvd_q, dvd_d;
  logic [width_p-1:0]     dsr_q, dsr_d;
  logic [width_p-1:0]     quot_q, quot_d;
  logic [width_p-1:0]     rem_q, rem_d;
  logic [width_p-1:0]     quotient_q, quotient_d;
  logic [width_p-1:0]     remainder_q, remainder_d;
  logic                   dbz_q, dbz_d;

  logic                       dividend_neg, divisor_neg;
  logic [width_p-1:0]         dividend_mag, divisor_mag;
  logic [LzW-1:0]             skip;
  logic [CntW-1:0]            prep_iters;
  logic [CntW-1:0]            count;
  logic [CntW-1:0]            cnt_up;
  logic                       cnt_down;
  logic [bits_per_iter_p-1:0] step_q;
  logic [width_p-1:0]         step_rem;

  assign dividend_neg = signed_q & dividend_q[width_p-1];
  assign divisor_neg  = signed_q & divisor_q[width_p-1];
  assign dividend_mag = dividend_neg ? -dividend_q : dividend_q;
  assign divisor_mag  = divisor_neg ? -divisor_q : divisor_q;

`ifdef BSG_IDIV_EARLY_TERM_EN
  logic [LzW-1:0] lz;

  // Leading-zero count of the dividend magnitude (width_p when zero).
  always_comb begin
    lz = LzW'(width_p);
    for (int i = 0; i < int'(width_p); i++) begin
      if (dividend_mag[i]) lz = LzW'(int'(width_p) - 1 - i);
    end
  end

  // Whole radix digits of leading zeros are skipped, never partial ones.
  assign skip       = (lz >> BShift) << BShift;
  assign prep_iters = CntW'(Iters) - CntW'(lz >> BShift);
`else
  assign skip       = '0;
  assign prep_iters = CntW'(Iters);
`endif

  bsg_idiv_radix_step #(
    .width_p        (width_p),
    .bits_per_iter_p(bits_per_iter_p)
  ) u_step (
    .partial_rem(rem_q),
    .dvd_bits   (dvd_q[width_p-1 -: bits_per_iter_p]),
    .divisor    (dsr_q),
    .quot_bits  (step_q),
    .next_rem   (step_rem)
  );

  bsg_counter_up_down #(
    .max_val_p(Iters)
  ) u_iter_cnt (
    .clk    (clk_i),
    .reset_n(reset_n_i),
    .up     (cnt_up),
    .down   (cnt_down),
    .count  (count)
  );

  // Controller: next state plus iteration-counter load/decrement.
  always_comb begin
    state_d  = state_q;
    cnt_up   = '0;
    cnt_down = 1'b0;
    unique case (state_q)
      StIdle: if (v_i) state_d = StPrep;
      StPrep: begin
        cnt_up  = prep_iters;
        state_d = (prep_iters == '0) ? StFix : StCalc;
      end
      StCalc: begin
        cnt_down = 1'b1;
        if (count == CntW'(1)) state_d = StFix;
      end
      StFix:  state_d = StDone;
      StDone: if (yumi_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state, staged by controller state.
  always_comb begin
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    signed_d    = signed_q;
    tag_d       = tag_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (v_i) begin
          dividend_d = dividend_i;
          divisor_d  = divisor_i;
          signed_d   = signed_i;
          tag_d      = tag_i;
        end
      end
      StPrep: begin
        q_neg_d = dividend_neg ^ divisor_neg;
        r_neg_d = dividend_neg;
        dvd_d   = dividend_mag << skip;
        dsr_d   = divisor_mag;
        quot_d  = '0;
        rem_d   = '0;
      end
      StCalc: begin
        rem_d  = step_rem;
        dvd_d  = dvd_q << bits_per_iter_p;
        quot_d = (quot_q << bits_per_iter_p) | width_p'(step_q);
      end
      StFix: begin
        if (divisor_q == '0) begin
          quotient_d  = '1;
          remainder_d = dividend_q;
          dbz_d       = 1'b1;
        end else begin
          // Most-negative / -1 needs no special case: negation wraps back.
          quotient_d  = q_neg_q ? -quot_q : quot_q;
          remainder_d = r_neg_q ? -rem_q : rem_q;
          dbz_d       = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= StIdle;
      dividend_q  <= '0;
      divisor_q   <= '0;
      signed_q    <= 1'b0;
      tag_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      signed_q    <= signed_d;
      tag_q       <= tag_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  // ready is gated by reset so it reads low while reset is held.
  assign ready_and_o   = (state_q == StIdle) & reset_n_i;
  assign v_o           = (state_q == StDone);
  assign quotient_o    = quotient_q;
  assign remainder_o   = remainder_q;
  assign div_by_zero_o = dbz_q;
  assign tag_o         = tag_q;

endmodule
